// File: rtl/config_scan_loader.sv
// config_scan_loader: streams host words LSB-first into a scan chain and
// returns the bits falling out of the chain tail as readback words.
module config_scan_loader #(
  parameter int CHAIN_LEN  = 64,
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  scan_in,
  output logic                  scan_en,
  output logic                  scan_wen,
  input  logic                  chain_tail,
  output logic [WORD_WIDTH-1:0] rb_data,
  output logic                  rb_valid,
  output logic                  busy,
  output logic                  done
);
  localparam int NW   = (CHAIN_LEN + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int LAST = ((CHAIN_LEN - 1) % WORD_WIDTH) + 1;
  localparam int WCW  = $clog2(NW + 1);
  localparam int SCW  = $clog2(CHAIN_LEN + 1);
  localparam int BCW  = $clog2(WORD_WIDTH + 1);
  localparam int RCW  = $clog2(WORD_WIDTH);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t                st_q, st_d;
  logic [WORD_WIDTH-1:0] hold_q, hold_d, sr_q, sr_d, rb_q, rb_d, rb_acc;
  logic                  hold_v_q, hold_v_d;
  logic [BCW-1:0]        cnt_q, cnt_d;
  logic [WCW-1:0]        acc_q, acc_d, mv_q, mv_d;
  logic [SCW-1:0]        sh_q, sh_d;
  logic [RCW-1:0]        rbc_q, rbc_d;
  logic                  go, hs, mv, shift, last, emit;
  // cnt_q is the number of valid bits left in the shift register; the chain
  // shifts on every edge where it is non-zero, so moving the next word in
  // while the last bit is consumed keeps streaming gapless.
  always_comb begin
    go       = start && (st_q == IDLE || st_q == DONE);
    hs       = in_valid && in_ready;
    shift    = cnt_q != '0;
    mv       = hold_v_q && cnt_q <= BCW'(1);
    last     = shift && sh_q == SCW'(CHAIN_LEN - 1);
    rb_acc   = rb_q;
    rb_acc[rbc_q] = chain_tail;
    emit     = shift && (rbc_q == RCW'(WORD_WIDTH - 1) || last);
    hold_d   = hs ? in_data : hold_q;
    hold_v_d = hs || (hold_v_q && !mv);
    sr_d     = mv ? hold_q : shift ? sr_q >> 1 : sr_q;
    cnt_d    = mv ? (mv_q == WCW'(NW - 1) ? BCW'(LAST) : BCW'(WORD_WIDTH))
             : shift ? cnt_q - BCW'(1) : cnt_q;
    acc_d    = go ? '0 : acc_q + WCW'(hs);
    mv_d     = go ? '0 : mv_q + WCW'(mv);
    sh_d     = go ? '0 : sh_q + SCW'(shift);
    rbc_d    = (go || emit) ? '0 : rbc_q + RCW'(shift);
    rb_d     = (go || emit) ? '0 : shift ? rb_acc : rb_q;
    st_d     = go ? LOAD : (st_q == LOAD && mv) ? SHIFT : last ? DONE : st_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= IDLE;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      sr_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mv_q     <= '0;
      sh_q     <= '0;
      rbc_q    <= '0;
      rb_q     <= '0;
      in_ready <= 1'b0;
      scan_in  <= 1'b0;
      scan_en  <= 1'b0;
      scan_wen <= 1'b0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      st_q     <= st_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mv_q     <= mv_d;
      sh_q     <= sh_d;
      rbc_q    <= rbc_d;
      rb_q     <= rb_d;
      in_ready <= !hold_v_d && acc_d < WCW'(NW) && (st_d == LOAD || st_d == SHIFT);
      scan_in  <= sr_d[0];
      scan_en  <= st_d == LOAD || st_d == SHIFT;
      scan_wen <= cnt_d != '0;
      rb_valid <= emit;
      if (emit) rb_data <= rb_acc;
      busy     <= st_d == LOAD || st_d == SHIFT;
      done     <= st_d == DONE;
    end
  end
endmodule

// File: doc/config_scan_loader.md
Name: config_scan_loader

Overview:
- Streams an FPGA configuration bitstream from a host word interface into the chain of scannable 1-bit configuration registers.
- Serialises words LSB-first onto the chain's scan_in, drives the chain's scan_en and wen, and counts exactly CHAIN_LEN shifts.
- Captures the bits falling out of the chain tail and returns them as readback words, so the host can verify prior contents.

Parameters:
- CHAIN_LEN, 64: number of scannable cells in the chain, i.e. total shift count. Must be >= 1.
- WORD_WIDTH, 8: host word width in bits. Must be >= 2.

Ports:
- clk  in  1  clock; all state changes on the posedge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  begin a load sequence. Sampled only in IDLE or DONE.
- in_data  in  WORD_WIDTH  bitstream word; bit 0 is shifted first.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts in_data this cycle.
- scan_in  out  1  serial data to the first chain cell.
- scan_en  out  1  chain scan-mode select.
- scan_wen  out  1  chain write enable; the chain shifts on each posedge where it is high.
- chain_tail  in  1  scan_out of the last chain cell.
- rb_data  out  WORD_WIDTH  readback word; bit 0 is the first bit captured.
- rb_valid  out  1  one-cycle pulse qualifying rb_data. No backpressure.
- busy  out  1  high in LOAD/SHIFT.
- done  out  1  high in DONE.

Behaviour:
- Reset: async; state=IDLE. All outputs are 0, all counters are 0, and the holding and shift registers are empty. Reset mid-load abandons the sequence; the chain keeps its partial contents.
- States and transitions:
  - IDLE -(start)-> LOAD.
  - LOAD -> SHIFT on the first word reaching the shift register.
  - SHIFT -> DONE on the CHAIN_LEN-th shift edge.
  - DONE -(start)-> LOAD.
  - start in LOAD/SHIFT is ignored.
- Words: NWORDS = ceil(CHAIN_LEN/WORD_WIDTH). The final word uses only its low ((CHAIN_LEN-1) mod WORD_WIDTH)+1 bits; the upper bits are discarded.
- Buffering: one holding register plus one shift register.
  - in_ready = holding empty AND words_accepted < NWORDS AND state in {LOAD, SHIFT}.
  - A handshake (in_valid & in_ready) loads holding.
  - holding moves to the shift register on an edge where the shift register is empty or is consuming its last valid bit.
- Outputs are flop-driven:
  - scan_in = shift register bit 0.
  - scan_wen = 1 exactly when the shift register holds a valid bit.
  - scan_en = 1 throughout LOAD and SHIFT.
- Latency: the first shift edge is the second posedge after the first handshake edge.
- Gapless streaming: with in_valid held high, scan_wen stays high for CHAIN_LEN consecutive cycles.
- Underflow: if the shift register and holding register are both empty, scan_wen=0 and the chain holds. Shifting resumes on the next word with no bit loss.
- Shift counter: width $clog2(CHAIN_LEN+1). It increments per scan_wen cycle and never exceeds CHAIN_LEN. No extra scan_wen pulse occurs after the last bit.
- Readback:
  - chain_tail is sampled on every shift edge, as the pre-shift tail value, and packed LSB-first.
  - rb_valid pulses for one cycle after each WORD_WIDTH samples, and after the final sample with a partial word zero-padded in the upper bits.
  - Exactly NWORDS rb_valid pulses per sequence.
- DONE: entered at the edge of the last shift. In the following cycle busy=0, done=1, scan_en=0, scan_wen=0 and in_ready=0. done stays high until start or rst.

Test Plan (CHAIN_LEN=10, WORD_WIDTH=4 unless noted):
- Nominal load: start, then words 0x5, 0xA, 0xF with in_valid held high.
  - scan_in over consecutive scan_wen cycles = 1,0,1,0,0,1,0,1,1,1.
  - Exactly 10 scan_wen cycles, no gaps.
  - Bits 2-3 of 0xF are discarded.
  - done=1 the cycle after.
- Readback: behavioural 10-cell chain model preloaded 0b1100110011 (cell nearest tail = LSB).
  - rb_data pulses 0x3, 0x3, 0x3 (the last is 2 bits, zero-padded).
  - The chain then holds the new pattern.
- Underflow stall: drop in_valid for 5 cycles after the first word.
  - scan_wen=0 for the stall, scan_en stays 1.
  - Shift count totals 10 and the output bit sequence matches the nominal case.
- Start while busy: pulse start mid-SHIFT.
  - No effect: shift count still ends at 10 and a single DONE occurs.
  - A start in DONE reloads a new sequence correctly.
- Async reset mid-shift: assert rst after 6 shifts, between edges.
  - All outputs drop to 0 immediately.
  - After release, state is IDLE and in_ready=0 until start.
- Edge sizing: CHAIN_LEN=8, WORD_WIDTH=8 gives one word 0x81 with scan_in 1,0,0,0,0,0,0,1 and one rb_valid. CHAIN_LEN=1 gives one shift and one rb_valid.
